// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline interlock for the 5-stage MIPS core.
//   - Load-use hazard: the EX load's destination matches a source that the ID instruction reads.
//   - HI/LO occupancy: an ID mult/div/mf*/mt* instruction waits while the
//     mult/div unit is starting or still busy.
//   stall holds PC and IF/ID; id_bubble selects a NOP into ID/EX.
//   Optional build macro HAZARD_STAT_EN adds saturating stall statistics
//   counters (stall_cycles, md_stall_cycles).
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | mult/div unit free, HI/LO valid
//   ST_MD_BUSY | mult/div in flight, md_cnt = remaining busy cycles

module hazard_stall_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_md_use,
   input  logic        ex_load,
   input  logic [4:0]  ex_wa,
   input  logic        ex_md_start,
   input  logic        ex_md_is_div,
`ifdef HAZARD_STAT_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] md_stall_cycles,
`endif
   output logic        stall,
   output logic        id_bubble,
   output logic        md_busy,
   output logic [3:0]  md_cnt
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MD_BUSY = 1'b1
   } state_e;

   // Latencies are 1..15 so they always fit the 4-bit counter.
   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   state_e     state_q, state_d;
   logic [3:0] md_cnt_q, md_cnt_d;

   logic rs_match;
   logic rt_match;
   logic lu_hit;
   logic md_hit;

   // Hazard detection; $0 is hardwired to zero so it never creates a dependency.
   always_comb begin
      rs_match = id_use_rs & (id_rs == ex_wa);
      rt_match = id_use_rt & (id_rt == ex_wa);
      lu_hit   = ex_load & (ex_wa != 5'd0) & (rs_match | rt_match);
      md_hit   = id_md_use & (ex_md_start | md_busy);
   end

   assign stall     = lu_hit | md_hit;
   assign id_bubble = stall;
   assign md_busy   = (state_q == ST_MD_BUSY);
   assign md_cnt    = md_cnt_q;

   // Mult/div occupancy FSM: next state and down-counter; a new start while busy is ignored.
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ex_md_start) begin
               state_d  = ST_MD_BUSY;
               md_cnt_d = ex_md_is_div ? DIV_CNT : MULT_CNT;
            end
         end
         ST_MD_BUSY: begin
            if (md_cnt_q <= 4'd1) begin
               state_d  = ST_IDLE;
               md_cnt_d = 4'd0;
            end else begin
               md_cnt_d = md_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            md_cnt_d = 4'd0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         md_cnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

`ifdef HAZARD_STAT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] md_stall_cycles_q;

   // Saturating counts of stalled cycles and of HI/LO-induced stall cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_q    <= 32'd0;
         md_stall_cycles_q <= 32'd0;
      end else begin
         if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (md_hit && (md_stall_cycles_q != 32'hFFFF_FFFF)) begin
            md_stall_cycles_q <= md_stall_cycles_q + 32'd1;
         end
      end
   end

   assign stall_cycles    = stall_cycles_q;
   assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-numbered reference model (busy window end).
module tb_hazard_stall_ctrl;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_wa = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_md_use = 1'b0;
   logic       ex_load = 1'b0, ex_md_start = 1'b0, ex_md_is_div = 1'b0;
   logic       stall, id_bubble, md_busy;
   logic [3:0] md_cnt;
`ifdef HAZARD_STAT_EN
   logic [31:0] stall_cycles, md_stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: HI/LO is busy in cycles (issue, busy_end].
   int cyc = 0;
   int busy_end = -1;
   longint m_stall = 0;
   longint m_md = 0;

   hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_md_use(id_md_use), .ex_load(ex_load), .ex_wa(ex_wa),
      .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
`ifdef HAZARD_STAT_EN
      .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles),
`endif
      .stall(stall), .id_bubble(id_bubble), .md_busy(md_busy), .md_cnt(md_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, compare 1 time unit later, advance model for the edge.
   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mdu, input logic ld,
                       input logic [4:0] wa, input logic st, input logic dv);
      bit act, lu, md, exp_stall;
      int exp_cnt;
      @(negedge clk);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_md_use = mdu;
      ex_load = ld; ex_wa = wa; ex_md_start = st; ex_md_is_div = dv;
      #1;
      act       = (cyc <= busy_end);
      exp_cnt   = act ? (busy_end - cyc + 1) : 0;
      lu        = ld && (wa != 5'd0) && ((urs && rs == wa) || (urt && rt == wa));
      md        = mdu && (st || act);
      exp_stall = lu || md;
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("id_bubble", 32'(id_bubble), 32'(exp_stall));
      chk("md_busy", 32'(md_busy), 32'(act));
      chk("md_cnt", 32'(md_cnt), 32'(exp_cnt));
`ifdef HAZARD_STAT_EN
      chk("stall_cycles", stall_cycles, 32'(m_stall));
      chk("md_stall_cycles", md_stall_cycles, 32'(m_md));
`endif
      if (st && !act) busy_end = cyc + (dv ? DIV_LAT : MULT_LAT);
      if (exp_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (md && m_md < 64'hFFFF_FFFF) m_md++;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset pulse in mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      id_use_rs = 1'b0; id_use_rt = 1'b0; id_md_use = 1'b0;
      ex_load = 1'b0; ex_md_start = 1'b0; ex_md_is_div = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_md_busy", 32'(md_busy), 32'd0);
      chk("rst_md_cnt", 32'(md_cnt), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
`ifdef HAZARD_STAT_EN
      chk("rst_stall_cycles", stall_cycles, 32'd0);
      chk("rst_md_stall_cycles", md_stall_cycles, 32'd0);
`endif
      busy_end = -1;
      m_stall = 0;
      m_md = 0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      // Power-on reset
      repeat (2) @(negedge clk);
      chk("por_md_busy", 32'(md_busy), 32'd0);
      chk("por_md_cnt", 32'(md_cnt), 32'd0);
      chk("por_stall", 32'(stall), 32'd0);
      // Load-use still stalls combinationally during reset
      ex_load = 1'b1; ex_wa = 5'd3; id_rt = 5'd3; id_use_rt = 1'b1;
      #1;
      chk("por_lu_stall", 32'(stall), 32'd1);
      ex_load = 1'b0; id_use_rt = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // lw $8 in EX, addu reading $8 in ID, then load gone
      step(5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      step(5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);
      // mult issue with dependent md instruction held in ID through T+6
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
      for (int i = 0; i < MULT_LAT; i++)
         step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("t3_release_stall", 32'(stall), 32'd0);
      chk("t3_release_busy", 32'(md_busy), 32'd0);
`ifdef HAZARD_STAT_EN
      chk("t6_stall_cycles", stall_cycles, 32'd7);
      chk("t6_md_stall_cycles", md_stall_cycles, 32'd6);
`endif

      // $0 destination never stalls
      step(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("t2_zero_reg", 32'(stall), 32'd0);
      // rt-only match, and rs match with use_rs low
      step(5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      step(5'd7, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);

      // div issue without md use, second start at T+3 ignored
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      idle(2);
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      chk("t4_no_reload", 32'(md_cnt), 32'(DIV_LAT - 2));
      idle(9);
      chk("t4_done", 32'(md_busy), 32'd0);

      // Load-use and md hazard together: one stall
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      step(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      idle(6);

      // div issue, reset in cycle T+4
      step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      idle(3);
      chk("t5_busy_before", 32'(md_busy), 32'd1);
      do_reset();
      idle(2);

      // Random traffic with small register indices to force matches
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), 1'($urandom));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
